// File: rtl/rf_access_ctrl_pkg.sv
// Shared types for the register-file access controller.
//  - Geometry constants (lanes, warps, registers, data width) and derived index widths.
//  - wb_entry_t: one buffered lane-masked writeback.
//  - dec_e: per-cycle arbitration outcome.
//  - mask_lanes(): zero the lanes of a per-lane data vector whose mask bit is clear.
package rf_access_ctrl_pkg;

  localparam int unsigned NumLanes = 8;
  localparam int unsigned NumWarps = 8;
  localparam int unsigned NumRegs  = 16;
  localparam int unsigned DataW    = 32;
  localparam int unsigned WarpW    = (NumWarps > 1) ? $clog2(NumWarps) : 1;
  localparam int unsigned AddrW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  typedef logic [WarpW-1:0]          warp_t;
  typedef logic [AddrW-1:0]          addr_t;
  typedef logic [NumLanes-1:0]       mask_t;
  typedef logic [NumLanes*DataW-1:0] lane_data_t;

  typedef struct packed {
    warp_t      warp;
    addr_t      addr;
    mask_t      mask;
    lane_data_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    DecIdle,
    DecRead,
    DecWrite,
    DecBoth
  } dec_e;

  function automatic lane_data_t mask_lanes(lane_data_t data, mask_t mask);
    lane_data_t res;
    res = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if (mask[i]) res[i*DataW +: DataW] = data[i*DataW +: DataW];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_access_ctrl_wb_fifo.sv
// Circular writeback buffer of wb_entry_t.
//  clk_i, rst_ni   : clock, synchronous active-low reset (empties the buffer)
//  push_i          : store push_entry_i at the tail (caller guarantees !full_o)
//  pop_i           : drop the head (caller guarantees !empty_o)
//  rd_*_i          : read request compared against every occupied entry
//  full_o, empty_o : occupancy from the registered count
//  head_o          : oldest entry
//  hazard_o        : per-slot RAW match against the read request
module rf_access_ctrl_wb_fifo
  import rf_access_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic [WarpW-1:0] rd_warp_i,
  input  logic [AddrW-1:0] rd_addr0_i,
  input  logic [AddrW-1:0] rd_addr1_i,
  output logic             full_o,
  output logic             empty_o,
  output wb_entry_t        head_o,
  output logic [Depth-1:0] hazard_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  wb_entry_t        mem_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset; occupancy is tracked by valid_q/count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    hazard_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      hazard_o[i] = valid_q[i] && (mem_q[i].warp == rd_warp_i) &&
                    ((mem_q[i].addr == rd_addr0_i) || (mem_q[i].addr == rd_addr1_i));
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: sole owner of the register block's warp selector,
// both read ports and the write port.
//  clk_i, rst_ni       : clock, synchronous active-low reset
//  wb_*                : writeback requests (valid/ready), buffered in a small FIFO
//  rd_*                : operand read requests, served when rd_ready_o is high
//  op_*                : registered operand bundle, one cycle after a served read
//  rf_*_o / rf_rdata_* : register block interface (combinational read data)
module rf_access_ctrl
  import rf_access_ctrl_pkg::*;
#(
  parameter int unsigned WbDepth   = 2,
  parameter int unsigned StarveMax = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_valid_i,
  output logic                      wb_ready_o,
  input  logic [WarpW-1:0]          wb_warp_i,
  input  logic [AddrW-1:0]          wb_addr_i,
  input  logic [NumLanes-1:0]       wb_mask_i,
  input  logic [NumLanes*DataW-1:0] wb_data_i,
  input  logic                      rd_valid_i,
  output logic                      rd_ready_o,
  input  logic [WarpW-1:0]          rd_warp_i,
  input  logic [AddrW-1:0]          rd_addr0_i,
  input  logic [AddrW-1:0]          rd_addr1_i,
  input  logic [NumLanes-1:0]       rd_mask_i,
  output logic                      op_valid_o,
  output logic [WarpW-1:0]          op_warp_o,
  output logic [NumLanes*DataW-1:0] op_data0_o,
  output logic [NumLanes*DataW-1:0] op_data1_o,
  output logic [WarpW-1:0]          rf_warp_selector_o,
  output logic [NumLanes-1:0]       rf_read_en_0_o,
  output logic [NumLanes-1:0]       rf_read_en_1_o,
  output logic [AddrW-1:0]          rf_raddr_0_o,
  output logic [AddrW-1:0]          rf_raddr_1_o,
  output logic [NumLanes-1:0]       rf_write_en_o,
  output logic [AddrW-1:0]          rf_waddr_o,
  output logic [NumLanes*DataW-1:0] rf_wdata_o,
  input  logic [NumLanes*DataW-1:0] rf_rdata_0_i,
  input  logic [NumLanes*DataW-1:0] rf_rdata_1_i
);

  localparam int unsigned StarveW = (StarveMax > 0) ? $clog2(StarveMax + 1) : 1;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, hazard;
  logic [WbDepth-1:0] hazard_vec;
  wb_entry_t          head, push_entry;
  dec_e               dec;
  logic               serve_rd, serve_wr, starve_inc;

  logic [StarveW-1:0]        starve_q, starve_d;
  logic [WarpW-1:0]          last_warp_q;
  logic                      op_valid_q;
  logic [WarpW-1:0]          op_warp_q;
  logic [NumLanes*DataW-1:0] op_data0_q, op_data1_q;

  assign push_entry = '{warp: wb_warp_i, addr: wb_addr_i, mask: wb_mask_i, data: wb_data_i};
  assign wb_ready_o = rst_ni && !fifo_full;
  assign fifo_push  = wb_valid_i && wb_ready_o;
  assign fifo_pop   = serve_wr;
  assign hazard     = |hazard_vec;

  rf_access_ctrl_wb_fifo #(
    .Depth (WbDepth)
  ) u_wb_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .rd_warp_i    (rd_warp_i),
    .rd_addr0_i   (rd_addr0_i),
    .rd_addr1_i   (rd_addr1_i),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .hazard_o     (hazard_vec)
  );

  // Priority arbitration; only entries present at the start of the cycle can hazard,
  // so a same-cycle push never blocks a read.
  always_comb begin
    dec        = DecIdle;
    starve_inc = 1'b0;
    if (!rst_ni) begin
      dec = DecIdle;
    end else if (fifo_empty) begin
      dec = rd_valid_i ? DecRead : DecIdle;
    end else if (rd_valid_i && !hazard && (rd_warp_i == head.warp)) begin
      // Same warp selected for both ports: write and read share the cycle.
      dec = DecBoth;
    end else if (fifo_full || (starve_q == StarveW'(StarveMax)) || hazard || !rd_valid_i) begin
      dec = DecWrite;
    end else begin
      dec        = DecRead;
      starve_inc = 1'b1;
    end
  end

  assign serve_rd = (dec == DecRead) || (dec == DecBoth);
  assign serve_wr = (dec == DecWrite) || (dec == DecBoth);

  always_comb begin
    rd_ready_o         = serve_rd;
    rf_read_en_0_o     = serve_rd ? rd_mask_i : '0;
    rf_read_en_1_o     = serve_rd ? rd_mask_i : '0;
    rf_raddr_0_o       = rd_addr0_i;
    rf_raddr_1_o       = rd_addr1_i;
    rf_write_en_o      = serve_wr ? head.mask : '0;
    rf_waddr_o         = head.addr;
    rf_wdata_o         = head.data;
    rf_warp_selector_o = last_warp_q;
    if (serve_rd)      rf_warp_selector_o = rd_warp_i;
    else if (serve_wr) rf_warp_selector_o = head.warp;
  end

  always_comb begin
    starve_d = starve_q;
    if (serve_wr)        starve_d = '0;
    else if (starve_inc) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q    <= '0;
      last_warp_q <= '0;
      op_valid_q  <= 1'b0;
      op_warp_q   <= '0;
      op_data0_q  <= '0;
      op_data1_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      op_valid_q <= serve_rd;
      if (serve_rd || serve_wr) last_warp_q <= rf_warp_selector_o;
      if (serve_rd) begin
        op_warp_q  <= rd_warp_i;
        op_data0_q <= mask_lanes(rf_rdata_0_i, rd_mask_i);
        op_data1_q <= mask_lanes(rf_rdata_1_i, rd_mask_i);
      end
    end
  end

  assign op_valid_o = op_valid_q;
  assign op_warp_o  = op_warp_q;
  assign op_data0_o = op_data0_q;
  assign op_data1_o = op_data1_q;

endmodule
